vga_channel_select: RTL and testbench
=====================================

// Module: vga_channel_select
// PURPOSE
//  N-channel VGA pixel-source selector for the clock/calendar/stopwatch display top.
//  Replaces the fixed two-way rgb mux with a keyboard-driven selector.
//  Pixel sources are pixel_gen-class blocks; key pulses come from the PS/2 decoder.
//  Channel changes take effect only at a frame boundary, followed by a programmable black gap.
//  Output is a p_tick-registered RGB word that drives the VGA DAC.
// PARAMETERS
//  NUM_CH        4   number of pixel sources, >=2
//  RGB_W         12  bits per pixel word
//  BLANK_FRAMES  2   black frames shown after a switch, 0..15; 0 = no gap
//  SEL_W         $clog2(NUM_CH), localparam
// PORTS
//  clk_100MHz      in   1              system clock
//  reset           in   1              synchronous, active-low
//  p_tick          in   1              pixel enable from vga_controller
//  video_on        in   1              active display area
//  frame_start     in   1              high with p_tick at x=0,y=0
//  key_next        in   1              1-cycle pulse: next enabled channel
//  key_prev        in   1              1-cycle pulse: previous enabled channel
//  key_direct      in   1              1-cycle pulse: jump to key_idx
//  key_idx         in   SEL_W          direct target index
//  ch_enable       in   NUM_CH         per-channel enable; disabled channels are skipped
//  ch_rgb          in   NUM_CH*RGB_W   channel k at bits [k*RGB_W +: RGB_W]
//  vga             out  RGB_W          registered pixel
//  active_ch       out  SEL_W          channel currently displayed
//  switching       out  1              high in PENDING or BLANK
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   vga=0, active_ch=0, state=IDLE, target=0, blank_cnt=0, switching=0.
//   Reset overrides any pending or in-progress switch.
//  Request decode, evaluated every clk cycle:
//   Priority: key_direct > key_next/key_prev.
//   key_next and key_prev together without key_direct = no request.
//   Base index = target in PENDING, active_ch otherwise.
//   next/prev = nearest enabled index after/before the base, modulo NUM_CH.
//   No enabled index other than the base -> request dropped.
//   key_direct to a disabled index, or to key_idx >= NUM_CH -> request dropped.
//  FSM:
//   IDLE: valid request with result != active_ch -> target=result, go PENDING.
//   PENDING: a new valid request overwrites target (last wins).
//     On frame_start & p_tick: active_ch<=target, blank_cnt<=BLANK_FRAMES.
//     Then go BLANK, or IDLE if BLANK_FRAMES==0.
//     target==active_ch at the frame_start -> go IDLE with no gap.
//   BLANK: on frame_start & p_tick, decrement blank_cnt; reaching 0 -> IDLE.
//     A request in BLANK sets target; the FSM goes to PENDING after blank_cnt hits 0.
//     That next frame_start then applies the switch.
//  Pixel path, updated only when p_tick==1 (1 p_tick latency):
//   vga <= (video_on && state!=BLANK && ch_enable[active_ch]) ? ch_rgb[active_ch] : 0.
//   A same-edge switch uses the new active_ch's pixel; that pixel is blanked when BLANK_FRAMES>0.
//   The active channel's enable dropping does not force a switch; output is black until re-enabled or changed.
//  switching = (state!=IDLE).
// STRUCTURE
//  Package vga_pkg: RGB_W default, COLOR_BLACK, FSM state enum {IDLE,PENDING,BLANK}.
//  Sub-module ch_wrap_search (NUM_CH): combinational.
//   Inputs: base, dir, enable mask. Outputs: found, index.
//   Instantiated once for next and once for prev.
//  Top: decode, FSM, blank counter, output register.
// TESTING
//  NUM_CH=4, all enabled, key_next mid-frame.
//   -> active_ch stays 0 until frame_start, then 1.
//   -> vga=0 for 2 full frames, then ch1 pixels.
//  ch_enable=4'b1011, active_ch=1, key_next.
//   -> target=3 (2 skipped); key_prev from 0 -> 3 (wrap).
//  key_next x3 within one frame from 0.
//   -> single switch to 3 at next frame_start.
//  key_direct idx=2 with key_next in the same cycle -> target=2.
//  key_direct to a disabled channel -> no state change, switching stays 0.
//  reset=0 asserted in BLANK with blank_cnt=1.
//   -> next cycle vga=0, active_ch=0, switching=0.
//   -> after reset release, ch0 pixels appear 1 p_tick later.
//  BLANK_FRAMES=0, switch 0->2.
//   -> first pixel of the frame is ch2; vga=0 whenever video_on=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA channel selector: default pixel width,
// the black pixel value and the switch FSM state encoding.
package vga_pkg;

    localparam int VGA_RGB_W = 12;

    localparam logic [VGA_RGB_W-1:0] COLOR_BLACK = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } sel_state_t;

endpackage

// File: rtl/ch_wrap_search.sv
// Combinational wrap-around search for the nearest enabled channel.
// Ports: base (start index, excluded), dir (1=upward, 0=downward),
//        enable (channel mask), found (a candidate exists), index (result).
module ch_wrap_search #(
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [SEL_W-1:0]  base,
    input  logic              dir,
    input  logic [NUM_CH-1:0] enable,
    output logic              found,
    output logic [SEL_W-1:0]  index
);

    // Walk from the farthest distance to the nearest so the nearest hit
    // is the last one written.
    always_comb begin
        int c;
        found = 1'b0;
        index = '0;
        c     = 0;
        for (int d = NUM_CH - 1; d >= 1; d--) begin
            if (dir)
                c = (int'(base) + d) % NUM_CH;
            else
                c = (int'(base) - d + NUM_CH) % NUM_CH;
            if (enable[c[SEL_W-1:0]]) begin
                found = 1'b1;
                index = c[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vga_channel_select.sv
// Keyboard-driven N-channel VGA pixel-source selector with frame-aligned
// switching and a programmable black gap after each switch.
// Ports: clk_100MHz/reset (sync, active-low), p_tick/video_on/frame_start
//        from the VGA controller, key_next/key_prev/key_direct/key_idx from
//        the PS/2 decoder, ch_enable/ch_rgb per source; outputs vga
//        (registered pixel), active_ch and switching.
module vga_channel_select
    import vga_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int RGB_W        = VGA_RGB_W,
    parameter int BLANK_FRAMES = 2,
    localparam int SEL_W       = $clog2(NUM_CH)
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic                    p_tick,
    input  logic                    video_on,
    input  logic                    frame_start,
    input  logic                    key_next,
    input  logic                    key_prev,
    input  logic                    key_direct,
    input  logic [SEL_W-1:0]        key_idx,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH*RGB_W-1:0] ch_rgb,
    output logic [RGB_W-1:0]        vga,
    output logic [SEL_W-1:0]        active_ch,
    output logic                    switching
);

    localparam logic [3:0]       GAP   = 4'(BLANK_FRAMES);
    localparam logic [RGB_W-1:0] BLACK = RGB_W'(COLOR_BLACK);

    sel_state_t       state;
    sel_state_t       state_n;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] target_n;
    logic [SEL_W-1:0] active_n;
    logic [SEL_W-1:0] tgt_eff;
    logic [SEL_W-1:0] base;
    logic [3:0]       blank_cnt;
    logic [3:0]       cnt_n;
    logic [RGB_W-1:0] pix_n;

    logic             nxt_found;
    logic             prv_found;
    logic [SEL_W-1:0] nxt_idx;
    logic [SEL_W-1:0] prv_idx;
    logic             req_ok;
    logic [SEL_W-1:0] req_idx;
    logic             fs;

    assign fs   = frame_start & p_tick;
    // Stepping in PENDING continues from the queued target, not the
    // channel still on screen.
    assign base = (state == PENDING) ? target : active_ch;

    ch_wrap_search #(.NUM_CH(NUM_CH)) u_next (
        .base   (base),
        .dir    (1'b1),
        .enable (ch_enable),
        .found  (nxt_found),
        .index  (nxt_idx)
    );

    ch_wrap_search #(.NUM_CH(NUM_CH)) u_prev (
        .base   (base),
        .dir    (1'b0),
        .enable (ch_enable),
        .found  (prv_found),
        .index  (prv_idx)
    );

    always_comb begin
        req_ok  = 1'b0;
        req_idx = key_idx;
        if (key_direct) begin
            req_ok  = (32'(key_idx) < NUM_CH) && ch_enable[key_idx];
            req_idx = key_idx;
        end else if (key_next && !key_prev) begin
            req_ok  = nxt_found;
            req_idx = nxt_idx;
        end else if (key_prev && !key_next) begin
            req_ok  = prv_found;
            req_idx = prv_idx;
        end
    end

    // A request arriving on the same cycle as the frame boundary is
    // folded in before the boundary action (last request wins).
    always_comb begin
        state_n  = state;
        target_n = target;
        active_n = active_ch;
        cnt_n    = blank_cnt;
        tgt_eff  = req_ok ? req_idx : target;
        unique case (state)
            IDLE: begin
                if (req_ok && req_idx != active_ch) begin
                    target_n = req_idx;
                    state_n  = PENDING;
                end
            end
            PENDING: begin
                target_n = tgt_eff;
                if (fs) begin
                    if (tgt_eff == active_ch) begin
                        state_n = IDLE;
                    end else begin
                        active_n = tgt_eff;
                        cnt_n    = GAP;
                        state_n  = (GAP == 4'd0) ? IDLE : BLANK;
                    end
                end
            end
            BLANK: begin
                target_n = tgt_eff;
                if (fs) begin
                    if (blank_cnt <= 4'd1) begin
                        cnt_n   = 4'd0;
                        state_n = (tgt_eff != active_ch) ? PENDING : IDLE;
                    end else begin
                        cnt_n = blank_cnt - 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pixel selection looks at the post-edge state so the frame that
    // starts on a switch edge already shows (or blanks) the new source.
    always_comb begin
        pix_n = BLACK;
        if (video_on && state_n != BLANK && ch_enable[active_n])
            pix_n = ch_rgb[32'(active_n)*RGB_W +: RGB_W];
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state     <= IDLE;
            target    <= '0;
            active_ch <= '0;
            blank_cnt <= '0;
            vga       <= BLACK;
        end else begin
            state     <= state_n;
            target    <= target_n;
            active_ch <= active_n;
            blank_cnt <= cnt_n;
            if (p_tick)
                vga <= pix_n;
        end
    end

    assign switching = (state != IDLE);

endmodule

// File: tb/tb_vga_channel_select.sv
// Directed bench for vga_channel_select: a frame-level model predicts
// every cycle, plus literal spot checks at the interesting points.
module tb_vga_channel_select;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HV = 6;
    localparam int VV = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         p_tick;
    logic         video_on;
    logic         frame_start;
    logic         key_next = 1'b0;
    logic         key_prev = 1'b0;
    logic         key_direct = 1'b0;
    logic [1:0]   key_idx = 2'd0;
    logic [N-1:0] ch_enable = 4'hF;
    logic [N*W-1:0] ch_rgb;
    logic [W-1:0] vga, vga0;
    logic [1:0]   active_ch, active0;
    logic         switching, switching0;

    int  x = 0;
    int  y = 0;
    bit  pt = 1'b0;
    bit  chk_en = 1'b0;
    int  n_pass = 0;
    int  n_total = 0;

    always #5 clk = ~clk;

    vga_channel_select #(.NUM_CH(N), .RGB_W(W), .BLANK_FRAMES(2)) dut (
        .clk_100MHz (clk),        .reset      (reset),
        .p_tick     (p_tick),     .video_on   (video_on),
        .frame_start(frame_start),.key_next   (key_next),
        .key_prev   (key_prev),   .key_direct (key_direct),
        .key_idx    (key_idx),    .ch_enable  (ch_enable),
        .ch_rgb     (ch_rgb),     .vga        (vga),
        .active_ch  (active_ch),  .switching  (switching)
    );

    vga_channel_select #(.NUM_CH(N), .RGB_W(W), .BLANK_FRAMES(0)) dut0 (
        .clk_100MHz (clk),        .reset      (reset),
        .p_tick     (p_tick),     .video_on   (video_on),
        .frame_start(frame_start),.key_next   (key_next),
        .key_prev   (key_prev),   .key_direct (key_direct),
        .key_idx    (key_idx),    .ch_enable  (ch_enable),
        .ch_rgb     (ch_rgb),     .vga        (vga0),
        .active_ch  (active0),    .switching  (switching0)
    );

    // Tiny raster: 8x4 positions, 6x3 visible, one p_tick every 2 clocks.
    always @(posedge clk) begin
        #1;
        if (pt) begin
            if (x == H - 1) begin
                x = 0;
                y = (y == V - 1) ? 0 : y + 1;
            end else begin
                x = x + 1;
            end
        end
        pt = !pt;
    end

    assign p_tick      = pt;
    assign video_on    = (x < HV) && (y < VV);
    assign frame_start = pt && (x == 0) && (y == 0);

    function automatic logic [W-1:0] pix(int k, int xx, int yy);
        return W'(((k + 1) << 8) | (xx << 4) | yy);
    endfunction

    always_comb begin
        ch_rgb = '0;
        for (int k = 0; k < N; k++)
            ch_rgb[k*W +: W] = pix(k, x, y);
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int          active;
        int          target;
        bit          pending;
        int          gap;
        logic [W-1:0] vga;
    } mdl_t;

    mdl_t m2 = '{0, 0, 1'b0, 0, '0};
    mdl_t m0 = '{0, 0, 1'b0, 0, '0};

    function automatic int nearest(int b, bit up);
        for (int d = 1; d < N; d++) begin
            int c;
            c = up ? (b + d) % N : (b - d + N) % N;
            if (ch_enable[c]) return c;
        end
        return -1;
    endfunction

    function automatic int request(int b);
        if (key_direct)
            return (int'(key_idx) < N && ch_enable[key_idx]) ? int'(key_idx) : -1;
        if (key_next && !key_prev) return nearest(b, 1'b1);
        if (key_prev && !key_next) return nearest(b, 1'b0);
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t m, int frames);
        bit fs;
        int r;
        if (!reset) return '{0, 0, 1'b0, 0, '0};
        fs = frame_start && p_tick;
        r  = request(m.pending ? m.target : m.active);
        if (m.gap > 0) begin
            if (r >= 0) m.target = r;
            if (fs) begin
                m.gap = m.gap - 1;
                if (m.gap == 0 && m.target != m.active) m.pending = 1'b1;
            end
        end else if (m.pending) begin
            if (r >= 0) m.target = r;
            if (fs) begin
                m.pending = 1'b0;
                if (m.target != m.active) begin
                    m.active = m.target;
                    m.gap    = frames;
                end
            end
        end else if (r >= 0 && r != m.active) begin
            m.target  = r;
            m.pending = 1'b1;
        end
        if (p_tick)
            m.vga = (video_on && m.gap == 0 && ch_enable[m.active])
                    ? pix(m.active, x, y) : '0;
        return m;
    endfunction

    always @(posedge clk) begin
        m2 = step(m2, 2);
        m0 = step(m0, 0);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("vga",        32'(vga),        32'(m2.vga));
            check("active_ch",  32'(active_ch),  32'(m2.active));
            check("switching",  32'(switching),  32'(m2.pending || m2.gap > 0));
            check("vga0",       32'(vga0),       32'(m0.vga));
            check("active_ch0", 32'(active0),    32'(m0.active));
            check("switching0", 32'(switching0), 32'(m0.pending || m0.gap > 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_fs();
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            @(posedge clk);
            hit = frame_start && p_tick;
        end
        if (!hit) check("frame_start_timeout", 32'(hit), 32'd1);
    endtask

    task automatic mid_frame();
        wait_fs();
        repeat (20) @(posedge clk);
    endtask

    task automatic pulse(bit n, bit p, bit d, logic [1:0] idx);
        @(posedge clk);
        #1;
        key_next = n; key_prev = p; key_direct = d; key_idx = idx;
        @(posedge clk);
        #1;
        key_next = 0; key_prev = 0; key_direct = 0; key_idx = 2'd0;
    endtask

    task automatic set_en(logic [N-1:0] v);
        @(posedge clk);
        #1;
        ch_enable = v;
    endtask

    task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        // reset state
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("rst_vga", 32'(vga), 32'h0);
        lit("rst_active", 32'(active_ch), 32'd0);
        lit("rst_switching", 32'(switching), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // next mid-frame: switch only at the frame boundary, then 2 black frames
        mid_frame();
        pulse(1, 0, 0, 2'd0);
        @(negedge clk);
        lit("t1_pending_sw", 32'(switching), 32'd1);
        lit("t1_pending_act", 32'(active_ch), 32'd0);
        wait_fs();
        @(negedge clk);
        lit("t1_switch_act", 32'(active_ch), 32'd1);
        lit("t1_model_act", 32'(m2.active), 32'd1);
        lit("t1_blank_vga", 32'(vga), 32'h0);
        lit("t1_nogap_vga", 32'(vga0), 32'h200);
        lit("t1_nogap_sw", 32'(switching0), 32'd0);
        wait_fs();
        wait_fs();
        @(negedge clk);
        lit("t1_after_gap_vga", 32'(vga), 32'h200);
        lit("t1_after_gap_sw", 32'(switching), 32'd0);

        // skip disabled channel 2, then wrap downward from 0
        set_en(4'b1011);
        mid_frame();
        pulse(1, 0, 0, 2'd0);
        wait_fs();
        @(negedge clk);
        lit("t2_skip_act", 32'(active_ch), 32'd3);
        wait_fs(); wait_fs();
        mid_frame();
        pulse(0, 0, 1, 2'd0);
        wait_fs(); wait_fs(); wait_fs();
        mid_frame();
        pulse(0, 1, 0, 2'd0);
        wait_fs();
        @(negedge clk);
        lit("t2_wrap_act", 32'(active_ch), 32'd3);
        lit("t2_model_wrap", 32'(m2.active), 32'd3);
        wait_fs(); wait_fs();

        // three nexts in one frame collapse into a single switch
        mid_frame();
        pulse(0, 0, 1, 2'd0);
        wait_fs(); wait_fs(); wait_fs();
        set_en(4'hF);
        mid_frame();
        pulse(1, 0, 0, 2'd0);
        pulse(1, 0, 0, 2'd0);
        pulse(1, 0, 0, 2'd0);
        @(negedge clk);
        lit("t3_still_0", 32'(active_ch), 32'd0);
        wait_fs();
        @(negedge clk);
        lit("t3_single_act", 32'(active_ch), 32'd3);
        wait_fs(); wait_fs();
        @(negedge clk);
        lit("t3_idle_sw", 32'(switching), 32'd0);

        // direct beats next
        mid_frame();
        pulse(1, 0, 1, 2'd2);
        wait_fs();
        @(negedge clk);
        lit("t4_direct_act", 32'(active_ch), 32'd2);
        wait_fs(); wait_fs();

        // direct to a disabled channel is dropped
        set_en(4'b1011);
        mid_frame();
        pulse(0, 0, 1, 2'd2);
        @(negedge clk);
        lit("t5_drop_sw", 32'(switching), 32'd0);
        lit("t5_drop_act", 32'(active_ch), 32'd2);

        // reset while blanking with one frame left
        pulse(1, 0, 0, 2'd0);
        wait_fs();
        wait_fs();
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lit("t6_rst_vga", 32'(vga), 32'h0);
        lit("t6_rst_act", 32'(active_ch), 32'd0);
        lit("t6_rst_sw", 32'(switching), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        wait_fs();
        @(negedge clk);
        lit("t6_ch0_vga", 32'(vga), 32'h100);

        // no-gap instance: first pixel of the switch frame is the new source
        set_en(4'hF);
        mid_frame();
        pulse(0, 0, 1, 2'd2);
        wait_fs();
        @(negedge clk);
        lit("t7_nogap_vga", 32'(vga0), 32'h300);
        lit("t7_nogap_act", 32'(active0), 32'd2);
        lit("t7_gap_vga", 32'(vga), 32'h0);
        wait_fs(); wait_fs();
        repeat (70) @(posedge clk);
        @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
